seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 207 ++++++++++++++++++++
 tb/tb_seg7_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Seven-segment bus sniffer: debounces each multiplexed digit and assembles a 16-bit frame.
// Optional dash support is enabled by defining SEG7_CAPTURE_TRACO_EN.
module seg7_capture #(
    parameter int unsigned ESTAVEL = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:6]  seg,
    input  logic [3:0]  anodo,
    input  logic        pronto,
    output logic [15:0] valor,
    output logic        valido,
    output logic [3:0]  traco,
    output logic        erro,
    output logic        overrun
);

    typedef enum logic [1:0] {OCIOSO, ESTAB, CAPT} state_t;

    state_t      state_q, state_d;
    logic [0:6]  seg_q;
    logic [3:0]  anodo_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  samp_an_q, samp_an_d;
    logic [0:6]  samp_seg_q, samp_seg_d;
    logic [3:0]  lock_q, lock_d;
    logic        lock_vld_q, lock_vld_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] work_q, work_d;
    logic [3:0]  dash_q, dash_d;
    logic [15:0] valor_q, valor_d;
    logic [3:0]  traco_q, traco_d;
    logic        valido_q, valido_d;
    logic        erro_q, erro_d;
    logic        overrun_q, overrun_d;

    logic [3:0]  sel_n;
    logic        one_hot;
    logic        locked;
    logic [1:0]  dig;
    logic        dec_ok;
    logic        dec_dash;
    logic [3:0]  dec_nib;
    logic        can_copy;

    assign sel_n   = ~anodo_q;
    assign one_hot = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
    // A digit already captured is ignored until the select lines move away from it.
    assign locked  = lock_vld_q && (anodo_q == lock_q);

    always_comb begin
        dig = 2'd0;
        unique case (~samp_an_q)
            4'b0010: dig = 2'd1;
            4'b0100: dig = 2'd2;
            4'b1000: dig = 2'd3;
            default: dig = 2'd0;
        endcase
    end

    always_comb begin
        dec_ok   = 1'b1;
        dec_dash = 1'b0;
        dec_nib  = 4'h0;
        case (samp_seg_q)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
`ifdef SEG7_CAPTURE_TRACO_EN
            7'b1111110: dec_dash = 1'b1;
`endif
            default:    dec_ok = 1'b0;
        endcase
    end

    // Stabilisation and capture FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        samp_an_d  = samp_an_q;
        samp_seg_d = samp_seg_q;
        lock_d     = lock_q;
        lock_vld_d = locked;
        mask_d     = (mask_q == 4'hF) ? 4'h0 : mask_q;
        work_d     = work_q;
        dash_d     = dash_q;
        erro_d     = 1'b0;
        unique case (state_q)
            OCIOSO: begin
                if (one_hot && !locked) begin
                    state_d    = ESTAB;
                    cnt_d      = 8'd1;
                    samp_an_d  = anodo_q;
                    samp_seg_d = seg_q;
                end
            end
            ESTAB: begin
                if (!one_hot) begin
                    state_d = OCIOSO;
                    cnt_d   = 8'd0;
                end else if ({anodo_q, seg_q} == {samp_an_q, samp_seg_q}) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(ESTAVEL)) state_d = CAPT;
                end else begin
                    cnt_d      = 8'd1;
                    samp_an_d  = anodo_q;
                    samp_seg_d = seg_q;
                end
            end
            CAPT: begin
                state_d    = OCIOSO;
                cnt_d      = 8'd0;
                lock_d     = samp_an_q;
                lock_vld_d = 1'b1;
                if (dec_ok) begin
                    work_d[dig*4 +: 4] = dec_nib;
                    mask_d[dig]        = 1'b1;
                    dash_d[dig]        = dec_dash;
                end else begin
                    erro_d = 1'b1;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    // Output frame hand-off; a completed frame is dropped if the consumer still holds the old one.
    assign can_copy = !valido_q || pronto;

    always_comb begin
        valor_d   = valor_q;
        traco_d   = traco_q;
        valido_d  = valido_q && !pronto;
        overrun_d = overrun_q;
        if (mask_q == 4'hF) begin
            if (can_copy) begin
                valor_d  = work_q;
                traco_d  = dash_q;
                valido_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q      <= 7'b1111111;
            anodo_q    <= 4'hF;
            state_q    <= OCIOSO;
            cnt_q      <= 8'd0;
            samp_an_q  <= 4'hF;
            samp_seg_q <= 7'b1111111;
            lock_q     <= 4'hF;
            lock_vld_q <= 1'b0;
            mask_q     <= 4'h0;
            work_q     <= 16'h0;
            dash_q     <= 4'h0;
            valor_q    <= 16'h0;
            traco_q    <= 4'h0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            seg_q      <= seg;
            anodo_q    <= anodo;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_an_q  <= samp_an_d;
            samp_seg_q <= samp_seg_d;
            lock_q     <= lock_d;
            lock_vld_q <= lock_vld_d;
            mask_q     <= mask_d;
            work_q     <= work_d;
            dash_q     <= dash_d;
            valor_q    <= valor_d;
            traco_q    <= traco_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
            overrun_q  <= overrun_d;
        end
    end

    assign valor   = valor_q;
    assign valido  = valido_q;
    assign erro    = erro_q;
    assign overrun = overrun_q;
`ifdef SEG7_CAPTURE_TRACO_EN
    assign traco   = traco_q;
`else
    assign traco   = 4'h0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: debounce, decode, frame hand-off, overrun, reset abort.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:6]  seg;
    logic [3:0]  anodo;
    logic        pronto;
    logic [15:0] valor;
    logic        valido;
    logic [3:0]  traco;
    logic        erro;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int erro_cnt = 0;

    seg7_capture #(.ESTAVEL(4)) dut (
        .clock(clk), .reset(reset), .seg(seg), .anodo(anodo), .pronto(pronto),
        .valor(valor), .valido(valido), .traco(traco), .erro(erro), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (erro === 1'b1) erro_cnt = erro_cnt + 1;

    function automatic logic [6:0] pat(input logic [3:0] n);
        case (n)
            4'h0: pat = 7'b0000001;  4'h1: pat = 7'b1001111;
            4'h2: pat = 7'b0010010;  4'h3: pat = 7'b0000110;
            4'h4: pat = 7'b1001100;  4'h5: pat = 7'b0100100;
            4'h6: pat = 7'b0100000;  4'h7: pat = 7'b0001111;
            4'h8: pat = 7'b0000000;  4'h9: pat = 7'b0000100;
            4'hA: pat = 7'b0001000;  4'hB: pat = 7'b1100000;
            4'hC: pat = 7'b0110001;  4'hD: pat = 7'b1000010;
            4'hE: pat = 7'b0110000;  default: pat = 7'b0111000;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_digit(input int d, input logic [6:0] p, input int n);
        logic [3:0] one;
        one   = 4'b0001 << d;
        anodo = ~one;
        seg   = p;
        step(n);
    endtask

    task automatic idle(input int n);
        anodo = 4'hF;
        seg   = 7'b1111111;
        step(n);
    endtask

    task automatic frame(input logic [15:0] v);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            nib = v[d*4 +: 4];
            drive_digit(d, pat(nib), 6);
        end
        idle(4);
    endtask

    task automatic consume();
        pronto = 1'b1;
        step(1);
        pronto = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pronto = 1'b0; anodo = 4'hF; seg = 7'b1111111;
        step(2);
        reset = 1'b0;
        check("rst_valor",   32'(valor),   32'h0);
        check("rst_valido",  32'(valido),  32'h0);
        check("rst_traco",   32'(traco),   32'h0);
        check("rst_erro",    32'(erro),    32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Basic frame 5, A, 0, F on digits 0..3.
        erro_cnt = 0;
        frame(16'hF0A5);
        check("f1_valor",   32'(valor),    32'hF0A5);
        check("f1_valido",  32'(valido),   32'h1);
        check("f1_traco",   32'(traco),    32'h0);
        check("f1_erro",    32'(erro_cnt), 32'h0);
        check("f1_overrun", 32'(overrun),  32'h0);

        // Second frame while first is unconsumed.
        frame(16'h1234);
        check("ovr_flag",   32'(overrun), 32'h1);
        check("ovr_valor",  32'(valor),   32'hF0A5);
        check("ovr_valido", 32'(valido),  32'h1);
        consume();
        check("ovr_clear",  32'(valido),  32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Short hold is not captured; a 4-sample hold is.
        drive_digit(0, pat(4'h1), 6);
        drive_digit(1, pat(4'h2), 6);
        drive_digit(2, pat(4'h3), 6);
        drive_digit(3, pat(4'h8), 3);
        idle(6);
        check("short_novld", 32'(valido), 32'h0);
        drive_digit(3, pat(4'h8), 4);
        idle(4);
        check("hold4_vld",   32'(valido), 32'h1);
        check("hold4_valor", 32'(valor),  32'h8321);
        consume();

        // Undecodable pattern on digit 0.
        erro_cnt = 0;
        drive_digit(0, 7'b1010101, 6);
        drive_digit(1, pat(4'h7), 6);
        drive_digit(2, pat(4'h7), 6);
        drive_digit(3, pat(4'h7), 6);
        idle(4);
        check("bad_erro1",  32'(erro_cnt), 32'h1);
        check("bad_novld",  32'(valido),   32'h0);
        drive_digit(0, pat(4'h7), 6);
        idle(4);
        check("bad_fix_valor", 32'(valor),  32'h7777);
        check("bad_fix_vld",   32'(valido), 32'h1);
        consume();

        // Dash on digit 2.
        erro_cnt = 0;
        drive_digit(0, pat(4'h7), 6);
        drive_digit(1, pat(4'h7), 6);
        drive_digit(2, 7'b1111110, 6);
        drive_digit(3, pat(4'h7), 6);
        idle(4);
`ifdef SEG7_CAPTURE_TRACO_EN
        check("dash_valor", 32'(valor),    32'h7077);
        check("dash_traco", 32'(traco),    32'h4);
        check("dash_vld",   32'(valido),   32'h1);
        check("dash_erro",  32'(erro_cnt), 32'h0);
`else
        check("dash_erro",  32'(erro_cnt), 32'h1);
        check("dash_novld", 32'(valido),   32'h0);
        check("dash_traco", 32'(traco),    32'h0);
`endif

        // Reset in the middle of digit 2.
        drive_digit(0, pat(4'h9), 6);
        drive_digit(1, pat(4'h9), 6);
        drive_digit(2, pat(4'h9), 2);
        reset = 1'b1;
        anodo = 4'hF; seg = 7'b1111111;
        step(1);
        reset = 1'b0;
        check("mid_rst_valor",   32'(valor),   32'h0);
        check("mid_rst_valido",  32'(valido),  32'h0);
        check("mid_rst_traco",   32'(traco),   32'h0);
        check("mid_rst_erro",    32'(erro),    32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        drive_digit(2, pat(4'h9), 6);
        drive_digit(3, pat(4'h9), 6);
        idle(4);
        check("post_rst_partial", 32'(valido), 32'h0);
        drive_digit(0, pat(4'h9), 6);
        drive_digit(1, pat(4'h9), 6);
        idle(4);
        check("post_rst_valor", 32'(valor),  32'h9999);
        check("post_rst_vld",   32'(valido), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
